// File: rtl/mt_seed_controller.sv
// Seeding and request sequencer for the mersenne_twister core: expands a 32-bit
// seed into N state words streamed to the core, then serves rv requests with a valid/ready port.
module mt_seed_controller #(
    parameter int          W           = 32,
    parameter int          N           = 624,
    parameter logic [31:0] INIT_MULT   = 32'h6C078965,
    parameter int          GEN_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_valid,
    input  logic [W-1:0] seed,
    output logic         seed_ready,
    output logic         seeded,
    output logic         busy,
    output logic         mt_load_value,
    output logic [W-1:0] mt_value,
    output logic         mt_gen_rv,
    input  logic [W-1:0] mt_rv,
    input  logic         rv_ready,
    output logic         rv_valid,
    output logic [W-1:0] rv_data,
    output logic [2:0]   fsm_state
);

    // Handshakes: a transfer happens on a posedge where valid && ready are both high;
    // rv_data/rv_valid hold steady while rv_valid && !rv_ready.
    localparam int IW = $clog2(N);
    localparam int CW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        READY = 3'd2,
        GEN   = 3'd3,
        WAIT  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  idx;
    logic [W-1:0]   prev;
    logic [CW-1:0]  wait_cnt;
    logic [W-1:0]   seed_word;
    logic           last_word;

    assign last_word = (idx == IW'(N - 1));
    assign seed_word = (idx == '0) ? prev
                     : INIT_MULT * (prev ^ (prev >> 30)) + W'(idx);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Seed acceptance wins over a pending rv request in READY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (seed_valid) state_next = SEED;
            SEED:    if (last_word) state_next = READY;
            READY: begin
                if (seed_valid)                state_next = SEED;
                else if (rv_ready && seeded)   state_next = GEN;
            end
            GEN:     state_next = WAIT;
            WAIT:    if (wait_cnt == CW'(1)) state_next = HOLD;
            HOLD:    if (rv_ready) state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seed_ready    = (state == IDLE) || (state == READY);
        busy          = (state == SEED) || (state == GEN) || (state == WAIT) || (state == HOLD);
        mt_load_value = (state == SEED);
        mt_value      = (state == SEED) ? seed_word : '0;
        mt_gen_rv     = (state == GEN);
        rv_valid      = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            prev     <= '0;
            seeded   <= 1'b0;
            wait_cnt <= '0;
            rv_data  <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (seed_valid) begin
                        prev   <= seed;
                        idx    <= '0;
                        seeded <= 1'b0;
                    end
                end
                SEED: begin
                    prev <= seed_word;
                    idx  <= idx + IW'(1);
                    if (last_word) begin
                        idx    <= '0;
                        seeded <= 1'b1;
                    end
                end
                GEN: wait_cnt <= CW'(GEN_LATENCY);
                WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    // The core's rv is valid in the last WAIT cycle.
                    if (wait_cnt == CW'(1)) rv_data <= mt_rv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mt_seed_controller.sv
// Directed/randomized bench for mt_seed_controller with a software model of the
// init recurrence and a fake core whose rv changes every cycle.
module tb_mt_seed_controller;

    localparam int N = 624;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [31:0] seed;
    logic        seed_ready;
    logic        seeded;
    logic        busy;
    logic        mt_load_value;
    logic [31:0] mt_value;
    logic        mt_gen_rv;
    logic [31:0] mt_rv;
    logic        rv_ready;
    logic        rv_valid;
    logic [31:0] rv_data;
    logic [2:0]  fsm_state;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] model [N];
    logic [31:0] obs_words [N];
    logic [31:0] rv_hist [int];
    int          pulse_q [$];

    mt_seed_controller #(.GEN_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready), .seeded(seeded), .busy(busy),
        .mt_load_value(mt_load_value), .mt_value(mt_value), .mt_gen_rv(mt_gen_rv),
        .mt_rv(mt_rv), .rv_ready(rv_ready), .rv_valid(rv_valid), .rv_data(rv_data),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void build_model(input logic [31:0] s);
        model[0] = s;
        for (int i = 1; i < N; i++)
            model[i] = 32'h6C078965 * (model[i-1] ^ (model[i-1] >> 30)) + 32'(i);
    endfunction

    // One clock: observe just after the edge, then present a fresh core rv.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mt_gen_rv === 1'b1) pulse_q.push_back(cyc);
        mt_rv = $urandom;
        rv_hist[cyc] = mt_rv;
    endtask

    // Called in the first SEED cycle; checks n_words words, stops mid-stream if n_words < N.
    task automatic check_stream(input logic [31:0] s, input int n_words);
        build_model(s);
        for (int i = 0; i < n_words; i++) begin
            obs_words[i] = mt_value;
            chk("load_value", 32'(mt_load_value), 1);
            chk("word", mt_value, model[i]);
            chk("seed_ready_in_seed", 32'(seed_ready), 0);
            chk("busy_in_seed", 32'(busy), 1);
            chk("seeded_in_seed", 32'(seeded), 0);
            chk("gen_in_seed", 32'(mt_gen_rv), 0);
            if (i == n_words - 1 && n_words < N) return;
            if (i == N - 1) begin
                seed_valid = 1'b0;
                rv_ready   = 1'b0;
            end else begin
                seed_valid = 1'($urandom_range(0, 1));
                seed       = $urandom;
                rv_ready   = 1'($urandom_range(0, 1));
            end
            step();
        end
        chk("load_after_stream", 32'(mt_load_value), 0);
        chk("seeded_after_stream", 32'(seeded), 1);
        chk("seed_ready_after_stream", 32'(seed_ready), 1);
        chk("busy_after_stream", 32'(busy), 0);
    endtask

    task automatic wait_rise(output int rise);
        rise = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rv_valid === 1'b1) begin
                rise = cyc;
                return;
            end
        end
    endtask

    // Waits for rv_valid, then ties it to the oldest gen_rv pulse.
    task automatic check_rise(input string tag, output int p);
        int rise;
        p = -1;
        wait_rise(rise);
        chk({tag, "_valid_timeout"}, 32'(rise >= 0), 1);
        if (rise < 0) return;
        chk({tag, "_pulse_seen"}, 32'(pulse_q.size() > 0), 1);
        if (pulse_q.size() == 0) return;
        p = pulse_q.pop_front();
        chk({tag, "_latency"}, 32'(rise - p), 32'(L + 1));
        chk({tag, "_data"}, rv_data, rv_hist[p + L]);
    endtask

    initial begin
        int          p;
        int          last_p;
        logic [31:0] s;
        logic [31:0] held;

        rst = 1'b1; seed_valid = 1'b0; seed = '0; rv_ready = 1'b0; mt_rv = '0;
        rv_hist[0] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seed_ready", 32'(seed_ready), 1);
        chk("rst_seeded", 32'(seeded), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load", 32'(mt_load_value), 0);
        chk("rst_value", mt_value, 0);
        chk("rst_gen", 32'(mt_gen_rv), 0);
        chk("rst_rv_valid", 32'(rv_valid), 0);
        chk("rst_rv_data", rv_data, 0);
        chk("rst_state", 32'(fsm_state), 0);
        rst = 1'b0;

        // rv requests before any seed are ignored.
        rv_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("unseeded_gen", 32'(mt_gen_rv), 0);
            chk("unseeded_rv_valid", 32'(rv_valid), 0);
            chk("unseeded_busy", 32'(busy), 0);
        end
        rv_ready = 1'b0;
        chk("unseeded_no_pulse", 32'(pulse_q.size()), 0);

        // seed = 0
        seed_valid = 1'b1; seed = 32'd0;
        step();
        seed_valid = 1'b0;
        check_stream(32'd0, N);
        chk("s0_w0", obs_words[0], 32'h00000000);
        chk("s0_w1", obs_words[1], 32'h00000001);
        chk("s0_w2", obs_words[2], 32'h6C078967);

        // seed = 5489 (reseed from READY)
        seed_valid = 1'b1; seed = 32'd5489;
        step();
        seed_valid = 1'b0;
        check_stream(32'd5489, N);
        chk("s5489_w1", obs_words[1], 32'h4D98EE96);

        // Ten back-to-back requests with rv_ready held high.
        pulse_q.delete();
        rv_ready = 1'b1;
        last_p = -1;
        for (int r = 0; r < 10; r++) begin
            check_rise("req", p);
            if (r > 0 && p >= 0 && last_p >= 0) chk("req_spacing", 32'(p - last_p), 32'(L + 3));
            last_p = p;
            step();
            chk("req_done_rv_valid", 32'(rv_valid), 0);
        end
        rv_ready = 1'b0;
        step();
        chk("idle_after_reqs_gen", 32'(mt_gen_rv), 0);
        chk("idle_after_reqs_busy", 32'(busy), 0);
        chk("no_extra_pulse", 32'(pulse_q.size()), 0);

        // Backpressure in HOLD, with a blocked seed request alongside.
        rv_ready = 1'b1;
        step();
        rv_ready = 1'b0;
        check_rise("bp", p);
        held = rv_data;
        seed_valid = 1'b1; seed = $urandom;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_rv_valid", 32'(rv_valid), 1);
            chk("bp_rv_data", rv_data, held);
            chk("bp_seed_ready", 32'(seed_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        seed_valid = 1'b0; rv_ready = 1'b1;
        step();
        rv_ready = 1'b0;
        chk("bp_done_rv_valid", 32'(rv_valid), 0);
        chk("bp_seed_blocked_load", 32'(mt_load_value), 0);
        chk("bp_seed_blocked_seeded", 32'(seeded), 1);

        // Seed and rv request together in READY: seed wins, request served afterwards.
        s = $urandom;
        seed_valid = 1'b1; seed = s; rv_ready = 1'b1;
        step();
        seed_valid = 1'b0;
        chk("prio_gen", 32'(mt_gen_rv), 0);
        chk("prio_load", 32'(mt_load_value), 1);
        check_stream(s, N);
        chk("prio_no_pulse", 32'(pulse_q.size()), 0);
        rv_ready = 1'b1;
        check_rise("pending", p);
        step();
        rv_ready = 1'b0;
        step();

        // Reset in the middle of a seed stream.
        s = $urandom;
        seed_valid = 1'b1; seed = s;
        step();
        seed_valid = 1'b0;
        check_stream(s, 101);
        #2;
        rst = 1'b1; seed_valid = 1'b0; rv_ready = 1'b0;
        #1;
        chk("midrst_load", 32'(mt_load_value), 0);
        chk("midrst_value", mt_value, 0);
        chk("midrst_seeded", 32'(seeded), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_gen", 32'(mt_gen_rv), 0);
        chk("midrst_rv_valid", 32'(rv_valid), 0);
        chk("midrst_rv_data", rv_data, 0);
        chk("midrst_state", 32'(fsm_state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("postrst_state", 32'(fsm_state), 0);
        chk("postrst_seeded", 32'(seeded), 0);

        s = $urandom;
        seed_valid = 1'b1; seed = s;
        step();
        seed_valid = 1'b0;
        check_stream(s, N);
        rv_ready = 1'b1;
        check_rise("final", p);
        step();
        rv_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_seed_controller.md
Name: mt_seed_controller

Overview:
Sequencing controller for the mersenne_twister core. On a seed request it expands a 32-bit seed into the full N-word initial state using the MT19937 init recurrence, and streams the words into the core one per cycle over load_value/value. Once seeded, it serves a consumer valid/ready port by pulsing gen_rv, waiting the core latency, and holding the captured rv until the consumer accepts it. It sits between system logic and the twister and is the only driver of the core's load_value, value and gen_rv.

Parameters:
W, 32, word width; the recurrence arithmetic is defined for 32 only.
N, 624, number of state words streamed per seed.
INIT_MULT, 32'h6C078965, init recurrence multiplier (1812433253).
GEN_LATENCY, 1, cycles from the gen_rv pulse to a valid core rv; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
seed_valid  in  1  seed request; accepted when seed_valid && seed_ready.
seed  in  W  seed value, sampled at acceptance.
seed_ready  out  1  high only in IDLE or READY.
seeded  out  1  high after a complete N-word load; cleared by reset or by a new seed acceptance.
busy  out  1  high in SEED, GEN, WAIT and HOLD.
mt_load_value  out  1  to core load_value; one word per asserted cycle.
mt_value  out  W  to core value; valid while mt_load_value is high.
mt_gen_rv  out  1  to core gen_rv; single-cycle pulse.
mt_rv  in  W  from core rv.
rv_ready  in  1  consumer request and accept.
rv_valid  out  1  consumer data valid.
rv_data  out  W  consumer data; stable while rv_valid && !rv_ready.

Behaviour:
- Reset (async assert, any state): state=IDLE; idx=0; prev=0; seeded=0; busy=0; all mt_* outputs=0; rv_valid=0; rv_data=0.
- IDLE: seed_ready=1. On seed accept: prev<=seed, idx<=0, seeded<=0, go to SEED.
- SEED: mt_load_value=1 every cycle; mt_value = (idx==0) ? prev : f(prev, idx).
  - f(p,i) = (INIT_MULT*(p ^ (p>>30)) + i) mod 2^32, i zero-extended to 32 bits.
  - Each cycle: prev<=mt_value; idx<=idx+1.
  - After the word with idx==N-1: seeded<=1, go to READY.
  - Exactly N back-to-back load cycles, no gaps. seed_valid, seed and rv_ready are ignored.
- READY: seed_ready=1. Seed accept has priority over rv_ready when both are present in the same cycle; the controller goes to SEED and the rv request stays pending.
  - Otherwise, if rv_ready && seeded: mt_gen_rv=1 for this one cycle, wait counter<=GEN_LATENCY, go to WAIT.
  - rv_ready in IDLE (unseeded) is ignored; rv_valid stays 0.
- WAIT: decrement the counter each cycle. When it reaches 0: rv_data<=mt_rv, rv_valid<=1, go to HOLD.
  - Net timing: rv_valid rises GEN_LATENCY+1 cycles after the gen_rv cycle.
- HOLD: rv_valid=1 and rv_data held.
  - If rv_ready: the transfer completes this cycle; rv_valid<=0 next cycle; go to READY.
  - Back-to-back requests therefore cost at least GEN_LATENCY+3 cycles each.
- GEN, WAIT and HOLD block seeding (seed_ready=0). The core's state is never reloaded mid-generate.
- Reset during SEED leaves the core partially loaded. seeded=0 until a full reload completes.
- idx width is $clog2(N). The multiply is a single-cycle 32x32 multiply with the low 32 bits kept.

Test Plan:
- Reset mid-SEED (assert rst at idx=100) -> all outputs 0 asynchronously, state IDLE, seeded=0; a reseed then produces a full 624-word stream.
- seed=0 -> mt_value sequence 0x00000000, 0x00000001, 0x6C078967, ...; exactly 624 consecutive mt_load_value cycles; seeded=1 on the cycle after the last load.
- seed=5489 -> word[1]=0x4D98EE96; all 624 words match a software model; seed_ready=0 throughout SEED.
- rv_ready before any seed -> no mt_gen_rv pulse, rv_valid stays 0.
- After seeding, rv_ready held high for 10 requests -> 10 single-cycle mt_gen_rv pulses, each rv_data equal to mt_rv sampled GEN_LATENCY cycles after its pulse, spacing GEN_LATENCY+3 cycles.
- Backpressure (rv_ready low for 5 cycles while in HOLD) -> rv_valid stays high and rv_data stable; simultaneous seed_valid and rv_ready in READY -> SEED is taken and no gen_rv pulse is issued.
